// File: rtl/gpio_in_pkg.sv
// Shared register map and address decode for the GPIO blocks.
// Used by gpio_in and by the output GPIO block for its address.
package gpio_in_pkg;

    localparam logic [31:0] GPIO_BASE_DEF = 32'h0000_ABD0;
    localparam logic [31:0] OFF_DATA      = 32'h0;
    localparam logic [31:0] OFF_EDGE      = 32'h4;
    localparam logic [31:0] OFF_MASK      = 32'h8;
    localparam int          DB_W          = 8;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DATA,
        SEL_EDGE,
        SEL_MASK
    } reg_sel_e;

    function automatic reg_sel_e reg_decode(
        input logic [31:0] a,
        input logic [31:0] base
    );
        reg_sel_e sel;
        sel = SEL_NONE;
        unique case (1'b1)
            (a == base + OFF_DATA): sel = SEL_DATA;
            (a == base + OFF_EDGE): sel = SEL_EDGE;
            (a == base + OFF_MASK): sel = SEL_MASK;
            default:                sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_in_if.sv
// Core-side load/store bus of the GPIO input block.
// The core drives the master side, gpio_in takes the slave side.
interface gpio_in_if;

    logic [31:0] A;
    logic        MemWrite;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Hit;

    modport master (
        output A, MemWrite, WD,
        input  RD, Hit
    );

    modport slave (
        input  A, MemWrite, WD,
        output RD, Hit
    );

endinterface

// File: rtl/gpio_in_debounce.sv
// One-bit pin conditioner: two-flop synchronizer plus optional debounce.
// Debounce counter exists only when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic rise
);

    if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db
        $error("gpio_in_debounce: DB_CYCLES out of range 2..255");
    end

    logic s1_q, s1_d;
    logic s2_q, s2_d;

`ifdef GPIO_IN_DEBOUNCE_EN
    logic            db_q, db_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = pin;
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = '0;
        // Count only while s2 disagrees; the final edge flips and rearms.
        if (s2_q != db_q) begin
            if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign stable = db_q;
    assign rise   = db_d & ~db_q;
`else
    always_comb begin
        s1_d = pin;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Without debounce the second sync flop is the DATA bit itself.
    assign stable = s2_q;
    assign rise   = s2_d & ~s2_q;
`endif

endmodule

// File: rtl/gpio_in.sv
// Memory-mapped GPIO input block: DATA, sticky EDGE (W1C), MASK, IRQ.
// Define GPIO_IN_DEBOUNCE_EN to enable per-pin debounce counters.
module gpio_in
    import gpio_in_pkg::*;
#(
    parameter int          DB_CYCLES = 4,
    parameter logic [31:0] BASE      = GPIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InGPIO,
    gpio_in_if.slave    bus,
    output logic        IRQ
);

    logic [31:0] data;
    logic [31:0] rise;
    logic [31:0] edge_q, edge_d;
    logic [31:0] mask_q, mask_d;
    reg_sel_e    sel;

    for (genvar i = 0; i < 32; i++) begin : g_pin
        gpio_in_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .pin   (InGPIO[i]),
            .stable(data[i]),
            .rise  (rise[i])
        );
    end

    assign sel = reg_decode(bus.A, BASE);

    always_comb begin
        edge_d = edge_q;
        mask_d = mask_q;
        if (bus.MemWrite && sel == SEL_EDGE) begin
            edge_d = edge_q & ~bus.WD;
        end
        // A rising bit on the same edge beats its clear.
        edge_d = edge_d | rise;
        if (bus.MemWrite && sel == SEL_MASK) begin
            mask_d = bus.WD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q <= '0;
            mask_q <= '0;
        end else begin
            edge_q <= edge_d;
            mask_q <= mask_d;
        end
    end

    always_comb begin
        bus.RD = '0;
        unique case (sel)
            SEL_DATA: bus.RD = data;
            SEL_EDGE: bus.RD = edge_q;
            SEL_MASK: bus.RD = mask_q;
            default:  bus.RD = '0;
        endcase
    end

    assign bus.Hit = (sel != SEL_NONE);
    assign IRQ     = |(edge_q & mask_q);

endmodule

// File: tb/tb_gpio_in.sv
// Scoreboard bench for gpio_in; follows GPIO_IN_DEBOUNCE_EN if defined.
// Expectations are queued with the stimulus and checked at the negedge.
module tb_gpio_in;

    localparam logic [31:0] B = 32'h0000_ABD0;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] addr;
        logic [31:0] exp;
    } sb_t;

    logic        clk;
    logic        reset;
    logic [31:0] InGPIO;
    logic        IRQ;
    int          n_vec;
    int          n_err;
    sb_t         sb_q[$];

    gpio_in_if bus();

    gpio_in #(
        .DB_CYCLES(4),
        .BASE     (B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .InGPIO(InGPIO),
        .bus   (bus),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int kind,
                        input logic [31:0] addr, input logic [31:0] exp);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.addr = addr;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.A = e.addr;
            #1;
            case (e.kind)
                0:       chk(e.tag, bus.RD, e.exp);
                1:       chk(e.tag, {31'b0, bus.Hit}, e.exp);
                default: chk(e.tag, {31'b0, IRQ}, e.exp);
            endcase
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        bus.A        = addr;
        bus.WD       = d;
        bus.MemWrite = 1'b1;
        @(negedge clk);
        bus.MemWrite = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        InGPIO       = 32'hFFFF_FFFF;
        bus.A        = '0;
        bus.WD       = '0;
        bus.MemWrite = 1'b0;

        cyc(3);
        push("rst_data", 0, B, 32'h0);
        push("rst_edge", 0, B + 4, 32'h0);
        push("rst_mask", 0, B + 8, 32'h0);
        push("rst_irq", 2, B, 32'h0);
        push("rst_hit", 1, B, 32'h1);
        drain();

        // Pin already high when reset lifts goes through the normal path.
        InGPIO = 32'h0000_0100;
        reset  = 1'b0;
        cyc(LAT);
        push("post_rst_early", 0, B, 32'h0);
        push("post_rst_edge_early", 0, B + 4, 32'h0);
        drain();
        cyc(1);
        push("post_rst_data", 0, B, 32'h100);
        push("post_rst_edge", 0, B + 4, 32'h100);
        drain();

        wr(B + 4, 32'h100);
        push("w1c_edge", 0, B + 4, 32'h0);
        push("w1c_data", 0, B, 32'h100);
        drain();

        InGPIO = 32'h0000_0101;
        cyc(LAT);
        push("rise_early", 0, B, 32'h100);
        push("rise_edge_early", 0, B + 4, 32'h0);
        drain();
        cyc(1);
        push("rise_data", 0, B, 32'h101);
        push("rise_edge", 0, B + 4, 32'h1);
        drain();

`ifdef GPIO_IN_DEBOUNCE_EN
        for (int i = 0; i < 11; i++) begin
            InGPIO = (i < 3) ? 32'h0000_0109 : 32'h0000_0101;
            cyc(1);
            push("glitch_data", 0, B, 32'h101);
            push("glitch_edge", 0, B + 4, 32'h1);
            drain();
        end
`endif

        wr(B + 4, 32'hFFFF_FFFF);
        InGPIO = 32'h0000_0100;
        cyc(LAT + 1);
        InGPIO = 32'h0000_0105;
        cyc(LAT + 1);
        push("edge5_data", 0, B, 32'h105);
        push("edge5_edge", 0, B + 4, 32'h5);
        push("irq_nomask", 2, B, 32'h0);
        drain();
        wr(B + 8, 32'h4);
        push("mask_rd", 0, B + 8, 32'h4);
        push("irq_on", 2, B, 32'h1);
        drain();
        wr(B + 4, 32'h4);
        push("clr_edge", 0, B + 4, 32'h1);
        push("clr_irq", 2, B, 32'h0);
        push("hit_mask", 1, B + 8, 32'h1);
        drain();

        InGPIO = 32'h0000_0101;
        cyc(LAT + 1);
        push("fall_edge", 0, B + 4, 32'h1);
        push("fall_data", 0, B, 32'h101);
        drain();
        InGPIO = 32'h0000_0105;
        cyc(LAT);
        push("pre_collide", 0, B + 4, 32'h1);
        drain();
        wr(B + 4, 32'h4);
        push("collide_edge", 0, B + 4, 32'h5);
        push("collide_data", 0, B, 32'h105);
        push("collide_irq", 2, B, 32'h1);
        drain();

        wr(B, 32'hFFFF_FFFF);
        push("ro_data", 0, B, 32'h105);
        push("miss_hit", 1, 32'h0, 32'h0);
        push("miss_rd", 0, 32'h0, 32'h0);
        push("miss_hit_c", 1, B + 12, 32'h0);
        drain();

        wr(B + 4, 32'hFFFF_FFFF);
        InGPIO = 32'hA5A5_0000;
        cyc(LAT);
        push("wide_early", 0, B, 32'h105);
        drain();
        cyc(1);
        push("wide_data", 0, B, 32'hA5A5_0000);
        push("wide_edge", 0, B + 4, 32'hA5A5_0000);
        push("wide_irq", 2, B, 32'h0);
        drain();

        // Reset in the middle of bit 0's debounce window.
        InGPIO = 32'hA5A5_0001;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        push("mid_rst_data", 0, B, 32'h0);
        push("mid_rst_edge", 0, B + 4, 32'h0);
        push("mid_rst_mask", 0, B + 8, 32'h0);
        push("mid_rst_irq", 2, B, 32'h0);
        drain();
        cyc(LAT);
        push("mid_rst_early", 0, B, 32'h0);
        drain();
        cyc(1);
        push("mid_rst_data2", 0, B, 32'hA5A5_0001);
        push("mid_rst_edge2", 0, B + 4, 32'hA5A5_0001);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
